// File: rtl/booth_mul_unit_if.sv
// Operand/result bundle between the EX stage and the Booth multiplier.
// The master drives the operands. The slave (the multiplier) returns stall and result.
interface booth_mul_unit_if #(
  parameter int WIDTH = 32
);
  logic [3:0]         alu_cnt;
  logic               start;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               stall;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;

  modport master (
    output alu_cnt, start, op_a, op_b,
    input  stall, busy, done, result
  );

  modport slave (
    input  alu_cnt, start, op_a, op_b,
    output stall, busy, done, result
  );
endinterface

// File: rtl/booth_mul_unit.sv
// Sequential radix-2 Booth multiplier, one step per cycle. It freezes the pipeline from accept until DONE.
// Latency: WIDTH+1 edges from accept to the done pulse. The unit ignores new requests until it returns to IDLE.
module booth_mul_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  booth_mul_unit_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;
  localparam logic [3:0] ALU_MUL = 4'b1000;

  logic [1:0]         state_q, state_d;
  logic [WIDTH:0]     a_q, a_d;
  logic [WIDTH:0]     m_q, m_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               q1_q, q1_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic [WIDTH:0]     sum;
  logic               accept;

  assign accept = (state_q == S_IDLE) && bus.start && (bus.alu_cnt == ALU_MUL);

  // A is WIDTH+1 bits wide, so subtracting M = -2**(WIDTH-1) cannot overflow.
  always_comb begin
    case ({q_q[0], q1_q})
      2'b01:   sum = a_q + m_q;
      2'b10:   sum = a_q - m_q;
      default: sum = a_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    m_d      = m_q;
    q_d      = q_q;
    q1_d     = q1_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          m_d     = {bus.op_a[WIDTH-1], bus.op_a};
          q_d     = bus.op_b;
          a_d     = '0;
          q1_d    = 1'b0;
          cnt_d   = CNT_W'(WIDTH);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d   = {sum[WIDTH], sum[WIDTH:1]};
        q_d   = {sum[0], q_q[WIDTH-1:1]};
        q1_d  = q_q[0];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d  = S_DONE;
          result_d = {a_d[WIDTH-1:0], q_d};
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      m_q      <= '0;
      q_q      <= '0;
      q1_q     <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      m_q      <= m_d;
      q_q      <= q_d;
      q1_q     <= q1_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign bus.stall  = !rst && (accept || (state_q == S_RUN));
  assign bus.busy   = (state_q == S_RUN);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_booth_mul_unit.sv
// Directed-vector bench for booth_mul_unit. A cycle-count/arithmetic model checks the outputs every cycle.
module tb_booth_mul_unit;
  localparam int WIDTH = 32;
  localparam logic [3:0] MUL = 4'b1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec  = 0;
  int   errs = 0;

  booth_mul_unit_if #(.WIDTH(WIDTH)) bif ();

  booth_mul_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  always #5 clk = ~clk;

  // Model: remaining RUN cycles, a done flag and the expected product from plain signed multiplication.
  int          m_left = 0;
  bit          m_done = 1'b0;
  logic [63:0] m_res  = '0;
  logic [63:0] m_pend = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0;
      m_done = 1'b0;
      m_res  = '0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_done = 1'b1;
        m_res  = m_pend;
      end
    end else if (bif.start && bif.alu_cnt == MUL) begin
      m_left = WIDTH;
      m_pend = $signed({{32{bif.op_a[31]}}, bif.op_a}) * $signed({{32{bif.op_b[31]}}, bif.op_b});
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic exp_busy, exp_stall;
    exp_busy  = (m_left > 0);
    exp_stall = !rst && (exp_busy || (!m_done && bif.start && bif.alu_cnt == MUL));
    chk("stall", 64'(bif.stall), 64'(exp_stall));
    chk("busy",  64'(bif.busy),  64'(exp_busy));
    chk("done",  64'(bif.done),  64'(m_done));
    chk("result", bif.result, m_res);
  end

  // Holds the MUL request until done, optionally swapping the operands at cycle chg_at, and counts stall cycles.
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp,
                        input string nm, input int chg_at);
    int stalls = 0;
    bit seen = 1'b0;
    @(posedge clk); #1;
    bif.alu_cnt = MUL; bif.start = 1'b1; bif.op_a = a; bif.op_b = b;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bif.stall) stalls++;
      if (bif.done) begin
        seen = 1'b1;
        chk({nm, "_result"}, bif.result, exp);
        chk({nm, "_model"}, m_res, exp);
        chk({nm, "_stall_cycles"}, 64'(stalls), 64'd33);
        break;
      end
      @(posedge clk); #1;
      if (i == chg_at) begin
        bif.op_a = 32'd2; bif.op_b = 32'd2;
      end
    end
    if (!seen) chk({nm, "_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    bif.alu_cnt = 4'b0000; bif.start = 1'b0; bif.op_a = '0; bif.op_b = '0;
    repeat (2) @(negedge clk);
    chk("reset_result", bif.result, 64'd0);
    chk("reset_stall", 64'(bif.stall), 64'd0);
    rst = 1'b0;

    do_mul(32'd3, 32'd5, 64'h0000_0000_0000_000F, "3x5", -1);
    do_mul(-32'sd7, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6, "m7x6", -1);
    do_mul(-32'sd7, -32'sd6, 64'h0000_0000_0000_002A, "m7xm6", -1);
    do_mul(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "min_x_min", -1);
    do_mul(32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, "min_x_m1", -1);

    // Non-MUL ALU op with a valid instruction, then MUL on a bubble: neither may be accepted.
    @(posedge clk); #1;
    bif.alu_cnt = 4'b0000; bif.start = 1'b1; bif.op_a = 32'd4; bif.op_b = 32'd4;
    repeat (4) @(posedge clk);
    #1 bif.alu_cnt = MUL; bif.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("no_accept_busy", 64'(bif.busy), 64'd0);
    chk("no_accept_result", bif.result, 64'h0000_0000_8000_0000);

    // Operands swapped mid-run must not disturb the product. The held 2x2 MUL is then accepted back-to-back.
    do_mul(32'd3, 32'd5, 64'd15, "3x5_hold", 9);
    do_mul(32'd2, 32'd2, 64'd4, "2x2_b2b", -1);

    @(posedge clk); #1;
    bif.start = 1'b0; bif.alu_cnt = 4'b0000;
    @(posedge clk); #1;
    bif.alu_cnt = MUL; bif.start = 1'b1; bif.op_a = 32'd9; bif.op_b = 32'd9;
    repeat (12) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_stall", 64'(bif.stall), 64'd0);
    chk("abort_busy", 64'(bif.busy), 64'd0);
    chk("abort_done", 64'(bif.done), 64'd0);
    chk("abort_result", bif.result, 64'd0);
    bif.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_mul(32'd9, 32'd9, 64'd81, "9x9_after_rst", -1);

    @(posedge clk); #1;
    bif.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
